// File: rtl/ddr_rd_test_sched.sv
// Job scheduler for the DDR bandwidth test: sequences NJOB read jobs through the read master and tallies beats/cycles.
// Optional DDR_RD_DATA_CHECK_EN adds address-pattern data checking (ERR_CNT_REG / ERR_ADDR_REG).
module ddr_rd_test_sched #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned BURST_LENGTH   = 7,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  START_REG,
    input  logic [31:0]           ADDR_REG,
    input  logic [31:0]           NBURST_REG,
    input  logic [31:0]           NJOB_REG,
    input  logic [31:0]           STRIDE_REG,
    output logic                  BUSY_REG,
    output logic                  DONE_REG,
    output logic                  TIMEOUT_REG,
    output logic [31:0]           CYCLES_REG,
    output logic [31:0]           BEATS_REG,
`ifdef DDR_RD_DATA_CHECK_EN
    output logic [31:0]           ERR_CNT_REG,
    output logic [31:0]           ERR_ADDR_REG,
`endif
    output logic                  rd_start,
    output logic [31:0]           rd_addr,
    output logic [31:0]           rd_nburst,
    input  logic                  rd_idle,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready
);

    localparam logic [31:0] BEATS_PER_BURST = 32'(BURST_LENGTH + 1);
    localparam logic [31:0] TIMEOUT_LIM     = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] SAT_MAX         = 32'hFFFF_FFFF;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state, state_d;
    logic        armed, armed_d;
    logic [31:0] njob_q, njob_d;
    logic [31:0] nburst_q, nburst_d;
    logic [31:0] stride_q, stride_d;
    logic [31:0] job_q, job_d;
    logic [31:0] job_beats_q, job_beats_d;
    logic [31:0] job_timer_q, job_timer_d;
    logic        busy_d, done_d, timeout_d, rd_start_d;
    logic [31:0] cycles_d, beats_d, rd_addr_d, rd_nburst_d;
    logic [31:0] job_target;
    logic        beat_acc;
    logic        in_xfer;

    assign beat_acc   = s_axis_tvalid & s_axis_tready;
    assign job_target = nburst_q * BEATS_PER_BURST;
    assign in_xfer    = (state == S_ISSUE) || (state == S_RUN);

`ifdef DDR_RD_DATA_CHECK_EN
    localparam int unsigned LANES      = DATA_WIDTH / 32;
    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;

    logic        err_seen, err_seen_d;
    logic [31:0] err_cnt_d, err_addr_d;
    logic [31:0] beat_addr;
    logic        beat_bad;

    // Beat i of a job carries lanes A+4j where A = job address + i*beat size.
    always_comb begin
        beat_addr = rd_addr + job_beats_q * 32'(BEAT_BYTES);
        beat_bad  = 1'b0;
        for (int j = 0; j < int'(LANES); j++) begin
            if (s_axis_tdata[32*j +: 32] != beat_addr + 32'(4 * j)) begin
                beat_bad = 1'b1;
            end
        end
    end
`else
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        armed_d     = armed | ~START_REG;
        njob_d      = njob_q;
        nburst_d    = nburst_q;
        stride_d    = stride_q;
        job_d       = job_q;
        job_beats_d = job_beats_q;
        job_timer_d = job_timer_q;
        busy_d      = BUSY_REG;
        done_d      = DONE_REG;
        timeout_d   = TIMEOUT_REG;
        cycles_d    = CYCLES_REG;
        beats_d     = BEATS_REG;
        rd_start_d  = rd_start;
        rd_addr_d   = rd_addr;
        rd_nburst_d = rd_nburst;
`ifdef DDR_RD_DATA_CHECK_EN
        err_seen_d  = err_seen;
        err_cnt_d   = ERR_CNT_REG;
        err_addr_d  = ERR_ADDR_REG;
`endif

        case (state)
            S_IDLE: begin
                if (START_REG && armed) begin
                    armed_d     = 1'b0;
                    njob_d      = NJOB_REG;
                    nburst_d    = NBURST_REG;
                    stride_d    = STRIDE_REG;
                    job_d       = 32'd0;
                    job_beats_d = 32'd0;
                    cycles_d    = 32'd0;
                    beats_d     = 32'd0;
                    timeout_d   = 1'b0;
`ifdef DDR_RD_DATA_CHECK_EN
                    err_seen_d  = 1'b0;
                    err_cnt_d   = 32'd0;
                    err_addr_d  = 32'd0;
`endif
                    if (NJOB_REG == 32'd0 || NBURST_REG == 32'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_WAIT;
                        busy_d      = 1'b1;
                        rd_addr_d   = ADDR_REG;
                        rd_nburst_d = NBURST_REG;
                    end
                end
            end
            S_WAIT: begin
                job_timer_d = 32'd0;
                job_beats_d = 32'd0;
                if (rd_idle) begin
                    state_d    = S_ISSUE;
                    rd_start_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!rd_idle) begin
                    state_d    = S_RUN;
                    rd_start_d = 1'b0;
                end
            end
            S_RUN: begin
                if (rd_idle && job_beats_q == job_target) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                job_d     = job_q + 32'd1;
                rd_addr_d = rd_addr + stride_q;
                if (job_d == njob_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (!START_REG) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Beat accounting and job timer; normal completion takes priority over a same-cycle timeout.
        if (in_xfer) begin
            if (beat_acc) begin
                job_beats_d = job_beats_q + 32'd1;
                if (BEATS_REG != SAT_MAX) beats_d = BEATS_REG + 32'd1;
`ifdef DDR_RD_DATA_CHECK_EN
                if (beat_bad) begin
                    if (ERR_CNT_REG != SAT_MAX) err_cnt_d = ERR_CNT_REG + 32'd1;
                    if (!err_seen) begin
                        err_seen_d = 1'b1;
                        err_addr_d = beat_addr;
                    end
                end
`endif
            end
            job_timer_d = job_timer_q + 32'd1;
            if (state_d != S_NEXT && job_timer_d == TIMEOUT_LIM) begin
                state_d    = S_DONE;
                rd_start_d = 1'b0;
                timeout_d  = 1'b1;
                busy_d     = 1'b0;
                done_d     = 1'b1;
            end
        end

        if ((in_xfer || state == S_WAIT || state == S_NEXT) && CYCLES_REG != SAT_MAX) begin
            cycles_d = CYCLES_REG + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            armed         <= 1'b0;
            njob_q        <= 32'd0;
            nburst_q      <= 32'd0;
            stride_q      <= 32'd0;
            job_q         <= 32'd0;
            job_beats_q   <= 32'd0;
            job_timer_q   <= 32'd0;
            BUSY_REG      <= 1'b0;
            DONE_REG      <= 1'b0;
            TIMEOUT_REG   <= 1'b0;
            CYCLES_REG    <= 32'd0;
            BEATS_REG     <= 32'd0;
            rd_start      <= 1'b0;
            rd_addr       <= 32'd0;
            rd_nburst     <= 32'd0;
            s_axis_tready <= 1'b0;
`ifdef DDR_RD_DATA_CHECK_EN
            err_seen      <= 1'b0;
            ERR_CNT_REG   <= 32'd0;
            ERR_ADDR_REG  <= 32'd0;
`endif
        end else begin
            state         <= state_d;
            armed         <= armed_d;
            njob_q        <= njob_d;
            nburst_q      <= nburst_d;
            stride_q      <= stride_d;
            job_q         <= job_d;
            job_beats_q   <= job_beats_d;
            job_timer_q   <= job_timer_d;
            BUSY_REG      <= busy_d;
            DONE_REG      <= done_d;
            TIMEOUT_REG   <= timeout_d;
            CYCLES_REG    <= cycles_d;
            BEATS_REG     <= beats_d;
            rd_start      <= rd_start_d;
            rd_addr       <= rd_addr_d;
            rd_nburst     <= rd_nburst_d;
            s_axis_tready <= 1'b1;
`ifdef DDR_RD_DATA_CHECK_EN
            err_seen      <= err_seen_d;
            ERR_CNT_REG   <= err_cnt_d;
            ERR_ADDR_REG  <= err_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_ddr_rd_test_sched.sv
// Directed bench for ddr_rd_test_sched with a read-master model and an issue scoreboard.
module tb_ddr_rd_test_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        START_REG;
    logic [31:0] ADDR_REG, NBURST_REG, NJOB_REG, STRIDE_REG;
    logic        BUSY_REG, DONE_REG, TIMEOUT_REG;
    logic [31:0] CYCLES_REG, BEATS_REG;
`ifdef DDR_RD_DATA_CHECK_EN
    logic [31:0] ERR_CNT_REG, ERR_ADDR_REG;
`endif
    logic        rd_start;
    logic [31:0] rd_addr, rd_nburst;
    logic        rd_idle;
    logic        s_axis_tvalid;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tready;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic rd_start_prev = 1'b0;
    logic [63:0] sb_q[$];

    logic        bfm_busy;
    logic        bfm_nodata = 1'b0;
    int          bfm_left;
    int          bfm_idx;
    int          corrupt_beat = -1;
    logic [31:0] bfm_addr;

    always #5 clk = ~clk;

    ddr_rd_test_sched #(
        .DATA_WIDTH(64),
        .BURST_LENGTH(7),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .START_REG(START_REG),
        .ADDR_REG(ADDR_REG),
        .NBURST_REG(NBURST_REG),
        .NJOB_REG(NJOB_REG),
        .STRIDE_REG(STRIDE_REG),
        .BUSY_REG(BUSY_REG),
        .DONE_REG(DONE_REG),
        .TIMEOUT_REG(TIMEOUT_REG),
        .CYCLES_REG(CYCLES_REG),
        .BEATS_REG(BEATS_REG),
`ifdef DDR_RD_DATA_CHECK_EN
        .ERR_CNT_REG(ERR_CNT_REG),
        .ERR_ADDR_REG(ERR_ADDR_REG),
`endif
        .rd_start(rd_start),
        .rd_addr(rd_addr),
        .rd_nburst(rd_nburst),
        .rd_idle(rd_idle),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tready(s_axis_tready)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (DONE_REG !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check1(tag, DONE_REG, 1'b1);
    endtask

    // Read-master model: accepts START when idle, streams NBURST*8 address-pattern beats, then returns idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bfm_busy      <= 1'b0;
            bfm_left      <= 0;
            bfm_idx       <= 0;
            bfm_addr      <= 32'd0;
            s_axis_tvalid <= 1'b0;
            s_axis_tdata  <= 64'd0;
        end else if (!bfm_busy) begin
            s_axis_tvalid <= 1'b0;
            if (rd_start) begin
                bfm_busy <= 1'b1;
                bfm_left <= int'(rd_nburst) * 8;
                bfm_addr <= rd_addr;
                bfm_idx  <= 0;
            end
        end else if (bfm_left > 0 && !bfm_nodata) begin
            s_axis_tvalid <= 1'b1;
            s_axis_tdata  <= {bfm_addr + 32'd4,
                              bfm_addr ^ ((bfm_idx == corrupt_beat) ? 32'hDEAD_BEEF : 32'h0)};
            bfm_addr      <= bfm_addr + 32'd8;
            bfm_left      <= bfm_left - 1;
            bfm_idx       <= bfm_idx + 1;
        end else if (bfm_left > 0) begin
            s_axis_tvalid <= 1'b0;
        end else begin
            s_axis_tvalid <= 1'b0;
            bfm_busy      <= 1'b0;
        end
    end
    assign rd_idle = ~bfm_busy;

    // Scoreboard: every rising rd_start must match the next expected {nburst, addr}.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rd_start === 1'b1 && rd_start_prev !== 1'b1) begin
            start_cnt++;
            if (sb_q.size() == 0) begin
                check32("sb_unexpected_start", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check32("issue_rd_addr", rd_addr, e[31:0]);
                check32("issue_rd_nburst", rd_nburst, e[63:32]);
            end
        end
        rd_start_prev <= rd_start;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        rst = 1'b1;
        START_REG  = 1'b1;
        ADDR_REG   = 32'd0;
        NBURST_REG = 32'd0;
        NJOB_REG   = 32'd0;
        STRIDE_REG = 32'd0;
        repeat (3) @(negedge clk);
        check1("rst_busy", BUSY_REG, 1'b0);
        check1("rst_done", DONE_REG, 1'b0);
        check1("rst_timeout", TIMEOUT_REG, 1'b0);
        check32("rst_cycles", CYCLES_REG, 32'd0);
        check32("rst_beats", BEATS_REG, 32'd0);
        check1("rst_rd_start", rd_start, 1'b0);
        check32("rst_rd_addr", rd_addr, 32'd0);
        check32("rst_rd_nburst", rd_nburst, 32'd0);
        check1("rst_tready", s_axis_tready, 1'b0);

        // START held across reset must not launch.
        NJOB_REG = 32'd1; NBURST_REG = 32'd1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check1("held_start_busy", BUSY_REG, 1'b0);
        check1("tready_out_of_reset", s_axis_tready, 1'b1);
        check32("held_start_issues", 32'(start_cnt), 32'd0);

        // Three jobs of four bursts; config change mid-run must be ignored.
        START_REG  = 1'b0;
        @(negedge clk);
        ADDR_REG   = 32'h1000_0000; NBURST_REG = 32'd4; NJOB_REG = 32'd3; STRIDE_REG = 32'h100;
        sb_q.push_back({32'd4, 32'h1000_0000});
        sb_q.push_back({32'd4, 32'h1000_0100});
        sb_q.push_back({32'd4, 32'h1000_0200});
        START_REG = 1'b1;
        repeat (4) @(negedge clk);
        check1("run_busy", BUSY_REG, 1'b1);
        NBURST_REG = 32'd9; ADDR_REG = 32'h5555_0000;
        wait_done("run3_done", 3000);
        check32("run3_beats", BEATS_REG, 32'd96);
        check1("run3_timeout", TIMEOUT_REG, 1'b0);
        check1("run3_busy", BUSY_REG, 1'b0);
        check1("run3_cycles_gt_beats", CYCLES_REG > 32'd96, 1'b1);
        check32("run3_sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        check1("done_held", DONE_REG, 1'b1);
        START_REG = 1'b0;
        @(negedge clk);
        check1("done_cleared", DONE_REG, 1'b0);

        // Empty run.
        base = start_cnt;
        NJOB_REG = 32'd0; NBURST_REG = 32'd4;
        START_REG = 1'b1;
        repeat (2) @(negedge clk);
        check1("empty_done", DONE_REG, 1'b1);
        check32("empty_beats", BEATS_REG, 32'd0);
        check32("empty_cycles", CYCLES_REG, 32'd0);
        check32("empty_issues", 32'(start_cnt - base), 32'd0);
        START_REG = 1'b0;
        repeat (2) @(negedge clk);

        // Master accepts start but never returns data.
        bfm_nodata = 1'b1;
        ADDR_REG = 32'h0000_3000; NJOB_REG = 32'd1; NBURST_REG = 32'd1;
        sb_q.push_back({32'd1, 32'h0000_3000});
        base = start_cnt;
        START_REG = 1'b1;
        n = 0;
        while (start_cnt == base && n < 50) begin
            @(negedge clk);
            n++;
        end
        check32("to_issued", 32'(start_cnt - base), 32'd1);
        n = 0;
        while (DONE_REG !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check1("to_done", DONE_REG, 1'b1);
        check1("to_timeout", TIMEOUT_REG, 1'b1);
        check1("to_rd_start", rd_start, 1'b0);
        check1("to_latency", (n >= 997 && n <= 1002), 1'b1);
        START_REG = 1'b0;
        bfm_nodata = 1'b0;
        n = 0;
        while (rd_idle !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("to_bfm_drained", rd_idle, 1'b1);
        check32("to_late_beats_dropped", BEATS_REG, 32'd0);

        // Address wrap; START dropped mid-run is ignored.
        ADDR_REG = 32'hFFFF_FF00; STRIDE_REG = 32'h100; NJOB_REG = 32'd2; NBURST_REG = 32'd1;
        sb_q.push_back({32'd1, 32'hFFFF_FF00});
        sb_q.push_back({32'd1, 32'h0000_0000});
        START_REG = 1'b1;
        repeat (3) @(negedge clk);
        START_REG = 1'b0;
        wait_done("wrap_done", 2000);
        check32("wrap_beats", BEATS_REG, 32'd16);
        check1("wrap_timeout_cleared", TIMEOUT_REG, 1'b0);
        check32("wrap_sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        // Reset pulse during job 1 with START held high.
        ADDR_REG = 32'h0000_2000; STRIDE_REG = 32'h40; NJOB_REG = 32'd3; NBURST_REG = 32'd4;
        sb_q.push_back({32'd4, 32'h0000_2000});
        sb_q.push_back({32'd4, 32'h0000_2040});
        base = start_cnt;
        START_REG = 1'b1;
        n = 0;
        while (start_cnt - base < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check32("rstmid_job1_issued", 32'(start_cnt - base), 32'd2);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check1("rstmid_busy", BUSY_REG, 1'b0);
        check1("rstmid_rd_start", rd_start, 1'b0);
        check32("rstmid_rd_addr", rd_addr, 32'd0);
        check32("rstmid_beats", BEATS_REG, 32'd0);
        check32("rstmid_cycles", CYCLES_REG, 32'd0);
        check1("rstmid_tready", s_axis_tready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check1("rstmid_no_relaunch", BUSY_REG, 1'b0);
        check32("rstmid_issue_count", 32'(start_cnt - base), 32'd2);
        START_REG = 1'b0;
        repeat (2) @(negedge clk);
        NJOB_REG = 32'd1;
        sb_q.push_back({32'd4, 32'h0000_2000});
        START_REG = 1'b1;
        wait_done("rearm_done", 2000);
        check32("rearm_beats", BEATS_REG, 32'd32);
        START_REG = 1'b0;
        repeat (2) @(negedge clk);

`ifdef DDR_RD_DATA_CHECK_EN
        check32("chk_clean_errs", ERR_CNT_REG, 32'd0);
        ADDR_REG = 32'h0000_1000; NJOB_REG = 32'd1; NBURST_REG = 32'd1;
        corrupt_beat = 5;
        sb_q.push_back({32'd1, 32'h0000_1000});
        START_REG = 1'b1;
        wait_done("chk_done", 2000);
        check32("chk_err_cnt", ERR_CNT_REG, 32'd1);
        check32("chk_err_addr", ERR_ADDR_REG, 32'h0000_1028);
        check32("chk_beats", BEATS_REG, 32'd8);
        START_REG = 1'b0;
        corrupt_beat = -1;
        repeat (2) @(negedge clk);
`endif

        check32("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
